game_flow_ctrl: RTL

Top-level game sequencer that owns the screen/game state of the design: title menu, pre-game countdown, play, pause and game-over. It takes the USB keycode and the VGA frame clock, and drives the menu sprite selector and the start/active strobes consumed by the game logic and the sprite renderer. Game logic reports a loss back through `game_over`, and the block returns to the menu after a timed game-over screen.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_flow_ctrl_if.sv | 29 ++
 rtl/game_flow_ctrl_frame_tick_gen.sv | 28 ++
 rtl/game_flow_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
// State encoding, USB HID key codes and menu sprite selects.
package game_pkg;

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_COUNT = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_ENTER = 8'h58;
  localparam logic [7:0] KEY_ESC   = 8'h29;
  localparam logic [7:0] KEY_P     = 8'h13;

  localparam logic [1:0] MENU_BLANK  = 2'b00;
  localparam logic [1:0] MENU_SINGLE = 2'b01;
  localparam logic [1:0] MENU_DOUBLE = 2'b10;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game flow bundle: keycode/game_over in, screen strobes out.
// slave = sequencer side, master = keyboard/game-logic side.
interface game_flow_ctrl_if;

  logic [7:0] keycode;
  logic       game_over;
  logic [1:0] menu_num;
  logic       start_game;
  logic       game_active;
  logic       paused;
  logic       two_player;
  logic [1:0] countdown;
  logic [2:0] state_out;

  modport master (
    output keycode, game_over,
    input  menu_num, start_game, game_active,
    input  paused, two_player, countdown,
    input  state_out
  );

  modport slave (
    input  keycode, game_over,
    output menu_num, start_game, game_active,
    output paused, two_player, countdown,
    output state_out
  );

endinterface

// File: rtl/game_flow_ctrl_frame_tick_gen.sv
// frame_tick_gen: 2-flop sync of frame_clk plus a registered
// rising-edge pulse. Ports: Clk, Reset, frame_clk_i, frame_tick_o.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk_i,
  output logic frame_tick_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       tick_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], frame_clk_i};
      prev_q <= sync_q[1];
      tick_q <= sync_q[1] & ~prev_q;
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: menu/countdown/play/pause/over sequencer.
// Ports: Clk, Reset, frame_clk, bus (slave). Option: GAME_PAUSE_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int COUNT_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  game_flow_ctrl_if.slave bus
);

  localparam logic [7:0] CNT_LAST =
    8'(COUNT_FRAMES - 1);
  localparam logic [7:0] OVER_LAST =
    8'(OVER_FRAMES - 1);

  game_state_t state_q, state_d;
  logic [1:0]  menu_q, menu_d;
  logic [1:0]  cd_q, cd_d;
  logic        two_q, two_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [7:0]  kprev_q, kprev_d;
  logic        start_q;
  logic        active_q;

  logic tick;
  logic press;
  logic k_up, k_down, k_enter, k_esc;
  logic go_menu;
`ifdef GAME_PAUSE_EN
  logic k_p;
  logic paused_q;
`endif

  frame_tick_gen u_tick (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk_i  (frame_clk),
    .frame_tick_o (tick)
  );

  // A held key acts once: only a change to non-zero counts.
  assign press = tick &&
                 (bus.keycode != 8'h00) &&
                 (bus.keycode != kprev_q);
  assign k_up    = press && (bus.keycode == KEY_UP);
  assign k_down  = press && (bus.keycode == KEY_DOWN);
  assign k_enter = press && (bus.keycode == KEY_ENTER);
  assign k_esc   = press && (bus.keycode == KEY_ESC);
`ifdef GAME_PAUSE_EN
  assign k_p     = press && (bus.keycode == KEY_P);
`endif

  always_comb begin
    state_d = state_q;
    menu_d  = menu_q;
    cd_d    = cd_q;
    two_d   = two_q;
    fcnt_d  = fcnt_q;
    kprev_d = tick ? bus.keycode : kprev_q;
    go_menu = 1'b0;

    case (state_q)
      ST_MENU: begin
        if (k_enter) begin
          if (menu_q != MENU_BLANK) begin
            state_d = ST_COUNT;
            two_d   = (menu_q == MENU_DOUBLE);
            cd_d    = 2'd3;
            fcnt_d  = 8'd0;
          end
        end else if (k_up) begin
          menu_d = MENU_SINGLE;
        end else if (k_down) begin
          menu_d = MENU_DOUBLE;
        end
      end

      ST_COUNT: begin
        if (k_esc) begin
          go_menu = 1'b1;
        end else if (tick) begin
          if (fcnt_q == CNT_LAST) begin
            fcnt_d = 8'd0;
            if (cd_q == 2'd1) begin
              cd_d    = 2'd0;
              state_d = ST_PLAY;
            end else begin
              cd_d = cd_q - 2'd1;
            end
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end

      ST_PLAY: begin
        // game_over is a level, seen every Clk.
        if (bus.game_over) begin
          state_d = ST_OVER;
          fcnt_d  = 8'd0;
        end else if (k_esc) begin
          go_menu = 1'b1;
        end
`ifdef GAME_PAUSE_EN
        else if (k_p) begin
          state_d = ST_PAUSE;
        end
`endif
      end

`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (k_esc) begin
          go_menu = 1'b1;
        end else if (k_p) begin
          state_d = ST_PLAY;
        end
      end
`endif

      ST_OVER: begin
        if (k_enter) begin
          go_menu = 1'b1;
        end else if (tick) begin
          if (fcnt_q == OVER_LAST) begin
            go_menu = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end

      default: go_menu = 1'b1;
    endcase

    if (go_menu) begin
      state_d = ST_MENU;
      menu_d  = MENU_BLANK;
      cd_d    = 2'd0;
      two_d   = 1'b0;
      fcnt_d  = 8'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_MENU;
      menu_q   <= MENU_BLANK;
      cd_q     <= 2'd0;
      two_q    <= 1'b0;
      fcnt_q   <= 8'd0;
      kprev_q  <= 8'd0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      menu_q   <= menu_d;
      cd_q     <= cd_d;
      two_q    <= two_d;
      fcnt_q   <= fcnt_d;
      kprev_q  <= kprev_d;
      start_q  <= (state_q == ST_COUNT) &&
                  (state_d == ST_PLAY);
      active_q <= (state_d == ST_PLAY);
    end
  end

`ifdef GAME_PAUSE_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      paused_q <= 1'b0;
    end else begin
      paused_q <= (state_d == ST_PAUSE);
    end
  end
  assign bus.paused = paused_q;
`else
  assign bus.paused = 1'b0;
`endif

  assign bus.menu_num    = menu_q;
  assign bus.start_game  = start_q;
  assign bus.game_active = active_q;
  assign bus.two_player  = two_q;
  assign bus.countdown   = cd_q;
  assign bus.state_out   = state_q;

endmodule
